// File: rtl/bp_cce_lce_cmd_send.sv
// Outbound LCE command sender for the microcoded CCE: single-destination headers or
// invalidation fan-out over a sharers mask, plus outstanding inv-ack accounting.
// Optional sticky ack-error flag: define BP_CCE_LCE_CMD_SEND_ACK_ERR_EN.
module bp_cce_lce_cmd_send #(
    parameter int num_lce_p         = 4,
    parameter int lce_id_width_p    = 2,
    parameter int paddr_width_p     = 40,
    parameter int lce_assoc_width_p = 3,
    parameter int coh_state_width_p = 3,
    localparam int cnt_width_lp     = $clog2(num_lce_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic                                   cmd_v_i,
    output logic                                   cmd_ready_o,
    input  logic                                   cmd_inv_i,
    input  logic [3:0]                             cmd_type_i,
    input  logic [lce_id_width_p-1:0]              cmd_dst_lce_i,
    input  logic [paddr_width_p-1:0]               cmd_addr_i,
    input  logic [lce_assoc_width_p-1:0]           cmd_way_i,
    input  logic [coh_state_width_p-1:0]           cmd_state_i,
    input  logic [num_lce_p-1:0]                   sharers_i,
    input  logic [num_lce_p*lce_assoc_width_p-1:0] sharers_way_i,
    input  logic [lce_id_width_p-1:0]              req_lce_i,

    output logic                                   lce_cmd_v_o,
    input  logic                                   lce_cmd_ready_i,
    output logic [3:0]                             lce_cmd_type_o,
    output logic [lce_id_width_p-1:0]              lce_cmd_dst_o,
    output logic [paddr_width_p-1:0]               lce_cmd_addr_o,
    output logic [lce_assoc_width_p-1:0]           lce_cmd_way_o,
    output logic [coh_state_width_p-1:0]           lce_cmd_state_o,

    input  logic                                   inv_ack_v_i,
    output logic [cnt_width_lp-1:0]                inv_pending_o,
    output logic                                   inv_done_o,
    output logic                                   ack_err_o
);

    typedef enum logic [1:0] {
        S_READY,
        S_SEND,
        S_INV
    } state_e;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [lce_id_width_p-1:0]    dst;
        logic [paddr_width_p-1:0]     addr;
        logic [lce_assoc_width_p-1:0] way;
        logic [coh_state_width_p-1:0] state;
    } hdr_s;

    state_e                                 state_q, state_d;
    hdr_s                                   hdr_q, hdr_d;
    logic [num_lce_p-1:0]                   mask_q, mask_d;
    logic [num_lce_p*lce_assoc_width_p-1:0] ways_q, ways_d;
    logic [cnt_width_lp-1:0]                pending_q, pending_d;

    logic [num_lce_p-1:0]                   fan_mask;
    logic [lce_id_width_p-1:0]              inv_idx;
    logic [lce_assoc_width_p-1:0]           inv_way;
    logic                                   inv_hs;
    logic                                   cnt_full;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        hdr_d     = hdr_q;
        mask_d    = mask_q;
        ways_d    = ways_q;
        pending_d = pending_q;

        fan_mask = sharers_i & ~(num_lce_p'(1) << req_lce_i);

        // Scan high-to-low so the lowest set bit wins.
        inv_idx = '0;
        inv_way = '0;
        for (int i = num_lce_p - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                inv_idx = lce_id_width_p'(i);
                inv_way = ways_q[i*lce_assoc_width_p +: lce_assoc_width_p];
            end
        end

        inv_hs   = (state_q == S_INV) && lce_cmd_ready_i;
        cnt_full = (pending_q == cnt_width_lp'(num_lce_p));

        case (state_q)
            S_READY: begin
                if (cmd_v_i) begin
                    if (cmd_inv_i) begin
                        // An empty fan-out is absorbed here: nothing to send, no state change.
                        if (fan_mask != '0) begin
                            mask_d  = fan_mask;
                            ways_d  = sharers_way_i;
                            hdr_d   = '{msg_type: cmd_type_i, dst: '0, addr: cmd_addr_i,
                                        way: '0, state: cmd_state_i};
                            state_d = S_INV;
                        end
                    end else begin
                        hdr_d   = '{msg_type: cmd_type_i, dst: cmd_dst_lce_i, addr: cmd_addr_i,
                                    way: cmd_way_i, state: cmd_state_i};
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (lce_cmd_ready_i) begin
                    state_d = S_READY;
                end
            end
            S_INV: begin
                if (lce_cmd_ready_i) begin
                    mask_d = mask_q & (mask_q - num_lce_p'(1));
                    if (mask_d == '0) begin
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_READY;
        endcase

        // A send and an ack in the same cycle cancel; acks at zero and sends at full are dropped.
        if (inv_hs && !inv_ack_v_i) begin
            if (!cnt_full) begin
                pending_d = pending_q + cnt_width_lp'(1);
            end
        end else if (!inv_hs && inv_ack_v_i && (pending_q != '0)) begin
            pending_d = pending_q - cnt_width_lp'(1);
        end

        cmd_ready_o     = (state_q == S_READY);
        lce_cmd_v_o     = (state_q != S_READY);
        lce_cmd_type_o  = hdr_q.msg_type;
        lce_cmd_addr_o  = hdr_q.addr;
        lce_cmd_state_o = hdr_q.state;
        lce_cmd_dst_o   = (state_q == S_INV) ? inv_idx : hdr_q.dst;
        lce_cmd_way_o   = (state_q == S_INV) ? inv_way : hdr_q.way;
    end

    assign inv_pending_o = pending_q;
    assign inv_done_o    = (pending_q == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_READY;
            hdr_q     <= '0;
            mask_q    <= '0;
            ways_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            mask_q    <= mask_d;
            ways_q    <= ways_d;
            pending_q <= pending_d;
        end
    end

`ifdef BP_CCE_LCE_CMD_SEND_ACK_ERR_EN
    logic ack_err_q, ack_err_d;

    always_comb begin
        ack_err_d = ack_err_q
                  | (inv_ack_v_i && !inv_hs && (pending_q == '0))
                  | (inv_hs && !inv_ack_v_i && cnt_full);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_d;
        end
    end

    assign ack_err_o = ack_err_q;
`else
    assign ack_err_o = 1'b0;
`endif

endmodule
